// File: rtl/trace_recorder.sv
// ----------------------------------------------------------------------------
// trace_recorder: per-bird circular history of sampled positions plus a
// registered per-pixel hit test that drives the trace bitmap renderer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trace_recorder #(
  parameter int DEPTH         = 8,
  parameter int SAMPLE_FRAMES = 4,
  parameter int SPRITE_SIZE   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        traceEnable,
  input  logic [10:0] bird1X,
  input  logic [10:0] bird1Y,
  input  logic        bird1Flying,
  input  logic        bird1Launch,
  input  logic [10:0] bird2X,
  input  logic [10:0] bird2Y,
  input  logic        bird2Flying,
  input  logic        bird2Launch,
  output logic [10:0] offsetX1,
  output logic [10:0] offsetY1,
  output logic        InsideRectangle1,
  output logic        trace1,
  output logic [10:0] offsetX2,
  output logic [10:0] offsetY2,
  output logic        InsideRectangle2,
  output logic        trace2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [5:0]    LAST_FRAME = 6'(SAMPLE_FRAMES - 1);
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [10:0]   SPRITE     = 11'(SPRITE_SIZE);

  logic [10:0] bird_x      [2];
  logic [10:0] bird_y      [2];
  logic        bird_fly    [2];
  logic        bird_launch [2];

  assign bird_x[0]      = bird1X;
  assign bird_y[0]      = bird1Y;
  assign bird_fly[0]    = bird1Flying;
  assign bird_launch[0] = bird1Launch;
  assign bird_x[1]      = bird2X;
  assign bird_y[1]      = bird2Y;
  assign bird_fly[1]    = bird2Flying;
  assign bird_launch[1] = bird2Launch;

  for (genvar b = 0; b < 2; b++) begin : g_bird
    logic [10:0]   mem_x [DEPTH];
    logic [10:0]   mem_y [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [5:0]    frame_cnt;
    logic          sample;

    logic          hit;
    logic [10:0]   hit_dx;
    logic [10:0]   hit_dy;
    logic [AW-1:0] idx;
    logic [11:0]   dx;
    logic [11:0]   dy;

    logic [10:0]   off_x_q;
    logic [10:0]   off_y_q;
    logic          inside_q;
    logic          trace_q;

    // Launch outranks a coincident sampling frame pulse.
    assign sample = startOfFrame && bird_fly[b] && !bird_launch[b] &&
                    (frame_cnt == LAST_FRAME);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr    <= '0;
        count     <= '0;
        frame_cnt <= '0;
      end else if (bird_launch[b]) begin
        wr_ptr    <= '0;
        count     <= '0;
        frame_cnt <= '0;
      end else if (startOfFrame && bird_fly[b]) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt <= '0;
          wr_ptr    <= wr_ptr + AW'(1);
          if (count != FULL) count <= count + CW'(1);
        end else begin
          frame_cnt <= frame_cnt + 6'd1;
        end
      end
    end

    // Point storage is gated by count, so it needs no reset.
    always_ff @(posedge clk) begin
      if (sample) begin
        mem_x[wr_ptr] <= bird_x[b];
        mem_y[wr_ptr] <= bird_y[b];
      end
    end

    // Walk from oldest to newest so the newest valid hit is the last to land.
    always_comb begin
      hit    = 1'b0;
      hit_dx = '0;
      hit_dy = '0;
      idx    = '0;
      dx     = '0;
      dy     = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        idx = wr_ptr - AW'(k + 1);
        dx  = {1'b0, pixelX} - {1'b0, mem_x[idx]};
        dy  = {1'b0, pixelY} - {1'b0, mem_y[idx]};
        if ((CW'(k) < count) && !dx[11] && !dy[11] &&
            (dx[10:0] < SPRITE) && (dy[10:0] < SPRITE)) begin
          hit    = 1'b1;
          hit_dx = dx[10:0];
          hit_dy = dy[10:0];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        off_x_q  <= '0;
        off_y_q  <= '0;
        inside_q <= 1'b0;
        trace_q  <= 1'b0;
      end else begin
        off_x_q  <= hit_dx;
        off_y_q  <= hit_dy;
        inside_q <= hit;
        trace_q  <= traceEnable && (count != '0);
      end
    end
  end

  assign offsetX1         = g_bird[0].off_x_q;
  assign offsetY1         = g_bird[0].off_y_q;
  assign InsideRectangle1 = g_bird[0].inside_q;
  assign trace1           = g_bird[0].trace_q;
  assign offsetX2         = g_bird[1].off_x_q;
  assign offsetY2         = g_bird[1].off_y_q;
  assign InsideRectangle2 = g_bird[1].inside_q;
  assign trace2           = g_bird[1].trace_q;

endmodule

`default_nettype wire

// File: doc/trace_recorder.md
# trace_recorder

Records the flight path of both birds as a short history of sampled positions and drives the per-pixel trace inputs of the trace bitmap renderer. Once per N frames while a bird is flying, the block stores that bird's top-left position in a per-bird circular buffer. On every pixel clock it tests the scan pixel against all stored points and outputs the trace enable, inside-rectangle flag and bitmap offsets for each bird. It sits between the bird movement controllers and the trace bitmap in the VGA object chain.

## Interface
- DEPTH, 8: stored trace points per bird. Power of two, 2..16.
- SAMPLE_FRAMES, 4: frames between samples, 1..63.
- SPRITE_SIZE, 32: square trace sprite edge in pixels. Power of two, at most 32.
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- pixelX, pixelY  in  11 each  current scan pixel.
- traceEnable  in  1  global show-traces switch.
- bird1X, bird1Y  in  11 each  bird 1 top-left position.
- bird1Flying  in  1  bird 1 in flight.
- bird1Launch  in  1  one-cycle pulse; clears bird 1 history.
- bird2X, bird2Y, bird2Flying, bird2Launch  in  11/11/1/1  same meanings for bird 2.
- offsetX1, offsetY1  out  11 each  pixel offset inside the matched bird 1 point; upper bits are 0.
- InsideRectangle1  out  1  pixel lies in at least one valid bird 1 point.
- trace1  out  1  bird 1 trace display enabled.
- offsetX2, offsetY2, InsideRectangle2, trace2  out  same for bird 2.

## Operation
- Per-bird state:
  - point RAM: DEPTH × (X, Y), 11 bits each.
  - wrPtr: log2(DEPTH) bits.
  - count: saturates at DEPTH.
  - frameCnt: 6 bits.
- frameCnt, on startOfFrame while that bird is Flying:
  - If frameCnt == SAMPLE_FRAMES-1: write (birdX, birdY) at wrPtr, increment wrPtr (wraps to 0 after DEPTH-1), count = min(count+1, DEPTH), frameCnt = 0.
  - Otherwise: frameCnt increments.
  - frameCnt holds while the bird is not Flying.
- Launch pulse: wrPtr, count and frameCnt go to 0 next cycle. Stored data need not be cleared; entries are gated by count.
- Launch and startOfFrame in the same cycle: Launch wins and no write occurs.
- Buffer full: the oldest entry (at wrPtr) is overwritten; count stays at DEPTH.
- Hit test for entry i (valid when i < count, counted back from newest):
  - dx = pixelX − X[i] and dy = pixelY − Y[i], computed at 12 bits signed.
  - Hit when 0 ≤ dx < SPRITE_SIZE and 0 ≤ dy < SPRITE_SIZE. Negative values are a miss; no wrap-around hits.
- Overlapping hits: the most recently written valid entry wins. Its dx and dy drive offsetX/offsetY, zero-extended to 11 bits.
- No hit: offsets are 0 and InsideRectangle is 0.
- traceN = traceEnable && (countN != 0).
- The two birds are fully independent. Bird 1 and bird 2 may overlap the same pixel; resolving between them is downstream.

## Timing
- Reset (asynchronous): all outputs 0, all counts, pointers and frameCnt 0.
- Hit outputs (offsets, InsideRectangle, trace) are registered: exactly 1 cycle after pixelX/pixelY/traceEnable.
- A sample written on the cycle of a startOfFrame pulse is visible to the hit test from the next cycle.
- Launch takes effect next cycle: count is 0, so InsideRectangle and trace drop on the cycle after that.
- Reset asserted mid-frame clears history immediately. After release, no sample is taken until the next startOfFrame.
- The RAM write and hit-test reads occur in the same cycle. The hit test sees pre-write contents on the write cycle.

## Test plan
- Reset: hold reset, drive pixels and Flying=1 with frame pulses → all outputs stay 0 and no samples are stored; release → first sample after SAMPLE_FRAMES frame pulses.
- Sampling: bird1 Flying at (100,200), SAMPLE_FRAMES=4, 4 frame pulses → count1=1. Pixel (110,205) → next cycle InsideRectangle1=1, offsetX1=10, offsetY1=5, trace1=1. Pixel (99,205) → InsideRectangle1=0, offsets 0.
- Wrap: 10 samples at X=0,40,…,360, Y=50 → count=8. Pixel (5,55) misses (entry overwritten). Pixel (365,55) hits with offsetX=5.
- Overlap priority: consecutive samples at (100,100) then (110,100); pixel (115,100) → offsetX1=5 (newest entry wins).
- Launch vs frame: Launch and the sampling startOfFrame in the same cycle → count 0, no write; trace1 falls 2 cycles after the Launch cycle.
- Independence: only bird 2 flying → trace1=0 and InsideRectangle1=0 throughout; traceEnable=0 → trace2=0 while InsideRectangle2 still asserts on hits.
